ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: the send side of the keyboard link, paired with the keyboard receiver.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) with the PS/2 inhibit/request-to-send sequence.
//  Drives PS/2 clock/data open-drain and checks the device ACK. Top ties: ps2_clk = o_clk_oe ? 1'b0 : 1'bz (same for data).
// PARAMETERS
//  INHIBIT_CYCLES  5000    clock-low hold before request-to-send (100 us @ 50 MHz)
//  RTS_CYCLES      50      data-low to clock-release delay inside inhibit window
//  TIMEOUT_CYCLES  750000  max i_clk cycles without a device falling edge (15 ms @ 50 MHz)
//  FILTER_LEN      4       consecutive equal samples needed to accept a PS/2 line level
// PORTS
//  i_clk         in   1  system clock (50 MHz)
//  i_rst         in   1  asynchronous, active-high reset
//  i_valid       in   1  request to send i_data; accepted only when o_ready=1
//  i_data        in   8  command byte
//  o_ready       out  1  1 in IDLE only
//  o_busy        out  1  1 from accept until DONE/ERR
//  o_done        out  1  1-cycle pulse: byte sent and ACK seen
//  o_err         out  1  1-cycle pulse: timeout or missing ACK
//  i_ps2_clk     in   1  PS/2 clock line level (async)
//  i_ps2_data    in   1  PS/2 data line level (async)
//  o_clk_oe      out  1  1 = pull PS/2 clock low
//  o_data_oe     out  1  1 = pull PS/2 data low
// BEHAVIOUR
//  Reset: all outputs 0 except o_ready=1; lines released immediately (async); filters reset to 1.
//  Input path: 2-flop sync per line, then FILTER_LEN-sample filter; fall = filtered clk 1->0 (1-cycle strobe).
//  Accept: i_valid & o_ready latches i_data and parity = ~^i_data (odd); o_ready drops next cycle.
//  FSM:
//   IDLE    -> INHIBIT on accept; cnt=0.
//   INHIBIT o_clk_oe=1; o_data_oe=1 once cnt >= INHIBIT_CYCLES-RTS_CYCLES; at cnt=INHIBIT_CYCLES-1 -> SEND.
//   SEND    o_clk_oe=0; data_oe holds start bit (0 => oe=1). bitidx=0.
//           each fall: drive frame bit bitidx = d0..d7, parity, stop(release); oe = ~bit; bitidx++.
//           after 10th fall (stop driven) -> ACK.
//   ACK     next fall: sample filtered data; 0 -> WAIT_IDLE, 1 -> ERR.
//   WAIT_IDLE wait for filtered clk=1 and data=1 -> DONE.
//   DONE    o_done=1 one cycle -> IDLE.   ERR: o_err=1 one cycle, both oe=0 -> IDLE.
//  Timeout: counter cleared on entry to SEND and on every fall; reaching TIMEOUT_CYCLES in SEND/ACK/WAIT_IDLE -> ERR.
//  Frame bits change only on the fall strobe; no change while clock high.
//  i_valid while busy: ignored, no queueing; i_data changes after accept: no effect.
//  o_err and o_done never in same cycle; o_busy=0 in the DONE/ERR pulse cycle.
//  Reset mid-frame: oe outputs drop asynchronously, FSM to IDLE, no done/err pulse.
//  Counters: cnt $clog2(INHIBIT_CYCLES) bits, timeout $clog2(TIMEOUT_CYCLES+1) bits, saturate, no wrap.
// TESTING  (sim params: INHIBIT_CYCLES=20, RTS_CYCLES=5, TIMEOUT_CYCLES=200, FILTER_LEN=2)
//  T1 send 0xED, device model clocks 11 falls, ACK low -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen; o_done=1 once.
//  T2 send 0x00 -> parity bit 1; send 0x01 -> parity 0; both o_done, o_err=0.
//  T3 device clocks 11 falls but holds data high at ACK -> o_err pulse, oe both 0, o_ready=1.
//  T4 device never clocks after release -> o_err exactly 200 cycles after SEND entry; lines released.
//  T5 i_valid with 0x55 while busy sending 0xFF -> ignored; only 0xFF on wire, single o_done.
//  T6 assert i_rst after 4th fall -> o_clk_oe=o_data_oe=0 same cycle, o_ready=1 after release, no pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the link, issues request-to-send, shifts one
// command byte out on device clock falls and checks the device ACK bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_clk_oe,
  output logic       o_data_oe,
  output logic [2:0] o_state
);

  localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_RTS  = CNT_W'(INHIBIT_CYCLES - RTS_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [TMO_W-1:0]      tmo;
  logic [3:0]            bit_idx;
  logic [9:0]            frame;
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_hist, data_hist;
  logic                  clk_filt, data_filt, fall;

  assign o_state = state;

  // Lines are asynchronous and may bounce: a level is accepted only after FILTER_LEN
  // identical synchronized samples; fall is a one-cycle strobe on the filtered clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= '1;
      data_hist <= '1;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      clk_hist  <= (clk_hist << 1) | FILTER_LEN'(clk_sync[1]);
      data_hist <= (data_hist << 1) | FILTER_LEN'(data_sync[1]);
      if (&clk_hist) clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      if (&data_hist) data_filt <= 1'b1;
      else if (~|data_hist) data_filt <= 1'b0;
      fall <= clk_filt & ~|clk_hist;
    end
  end

  // Handshake: a byte is taken on any cycle where i_valid and o_ready are both 1;
  // o_ready is 1 only in IDLE, so requests made while busy are dropped, not queued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tmo       <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_clk_oe  <= 1'b0;
      o_data_oe <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (fall) tmo <= '0;
      else if (tmo != TMO_MAX) tmo <= tmo + TMO_W'(1);

      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            frame     <= {1'b1, ~^i_data, i_data};
            cnt       <= '0;
            state     <= S_INHIBIT;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            o_clk_oe  <= 1'b1;
            o_data_oe <= (RTS_CYCLES >= INHIBIT_CYCLES);
          end
        end
        S_INHIBIT: begin
          if (cnt == CNT_LAST) begin
            // Release clock with data still low: the device now owns the clock.
            state     <= S_SEND;
            o_clk_oe  <= 1'b0;
            o_data_oe <= 1'b1;
            bit_idx   <= '0;
            tmo       <= '0;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            o_data_oe <= ((cnt + CNT_W'(1)) >= CNT_RTS);
          end
        end
        S_SEND: begin
          if (fall) begin
            o_data_oe <= ~frame[bit_idx];
            bit_idx   <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) state <= S_ACK;
          end else if (tmo == TMO_LAST) begin
            state     <= S_ERR;
            o_err     <= 1'b1;
            o_busy    <= 1'b0;
            o_data_oe <= 1'b0;
          end
        end
        S_ACK: begin
          if (fall && !data_filt) begin
            state <= S_WAIT_IDLE;
          end else if (fall || tmo == TMO_LAST) begin
            state     <= S_ERR;
            o_err     <= 1'b1;
            o_busy    <= 1'b0;
            o_data_oe <= 1'b0;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_filt && data_filt) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (!fall && tmo == TMO_LAST) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        S_DONE, S_ERR: begin
          state     <= S_IDLE;
          o_ready   <= 1'b1;
          o_clk_oe  <= 1'b0;
          o_data_oe <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          o_ready   <= 1'b1;
          o_busy    <= 1'b0;
          o_clk_oe  <= 1'b0;
          o_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// per-cycle monitor checks line ownership and status against the protocol rules.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 5;
  localparam int TMO = 200;
  localparam int FLT = 2;
  localparam int W   = 1;

  logic       clk, rst;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready, o_busy, o_done, o_err, o_clk_oe, o_data_oe;
  logic [2:0] o_state;
  logic       dev_clk, dev_data;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_line  = !o_clk_oe && dev_clk;
  assign ps2_data_line = !o_data_oe && dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .i_ps2_clk (ps2_clk_line),
    .i_ps2_data(ps2_data_line),
    .o_clk_oe  (o_clk_oe),
    .o_data_oe (o_data_oe),
    .o_state   (o_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [9:0]  cap_frame;
  int          half = 10;
  int          since = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          last_err_since = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame on the wire: d0..d7 LSB first, odd parity, stop high.
  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(b[i]));
    exp_q.push_back(W'(($countones(b) % 2) == 0));
    exp_q.push_back(W'(1));
  endfunction

  // ---------------- per-cycle compare process ----------------
  initial begin
    bit   acc_prev;
    logic prev_busy, prev_doe;
    acc_prev  = 1'b0;
    prev_busy = 1'b0;
    prev_doe  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        since     = 0;
        acc_prev  = 1'b0;
        prev_busy = 1'b0;
        prev_doe  = 1'b0;
      end else begin
        if (acc_prev) since = 1;
        else if (since > 0) since++;
        check("status_onehot", $countones({o_ready, o_busy, o_done, o_err}), 1);
        if (!o_busy) begin
          check("clk_oe_released", o_clk_oe, 0);
          check("data_oe_released", o_data_oe, 0);
        end
        if (since >= 1 && since <= INH) begin
          check("inhibit_clk_oe", o_clk_oe, 1);
          check("inhibit_data_oe", o_data_oe, since > INH - RTS);
          check("inhibit_busy", o_busy, 1);
        end else if (since == INH + 1) begin
          check("rts_clk_oe", o_clk_oe, 0);
          check("rts_data_oe", o_data_oe, 1);
          check("rts_busy", o_busy, 1);
        end else if (since > INH + 1 && o_busy) begin
          check("send_clk_oe", o_clk_oe, 0);
          if (prev_busy && o_data_oe != prev_doe) check("data_change_clk_low", dev_clk, 0);
        end
        if (o_done) done_cnt++;
        if (o_err) begin
          err_cnt++;
          last_err_since = since;
        end
        if (o_done || o_err) since = 0;
        prev_busy = o_busy;
        prev_doe  = o_data_oe;
        acc_prev  = i_valid && o_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!o_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_send", o_ready, 1);
    i_valid = 1'b1;
    i_data  = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic device_run(input int n_falls, input bit ack);
    int n;
    n = 0;
    cap_frame = '0;
    @(posedge clk); #1;
    while (!(ps2_clk_line && !ps2_data_line && o_busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rts_seen", n < 200, 1);
    if (n < 200) begin
      repeat (5) @(posedge clk);
      #1;
      check("start_bit", ps2_data_line, 0);
      for (int p = 1; p <= n_falls; p++) begin
        if (p == 11 && ack) dev_data = 1'b0;
        repeat (half) @(posedge clk);
        #1 dev_clk = 1'b0;
        repeat (half) @(posedge clk);
        #1;
        if (p <= 10) begin
          cap_frame[p-1] = ps2_data_line;
          check("exp_q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("frame_bit", ps2_data_line, exp_q.pop_front());
        end
        dev_clk = 1'b1;
        if (p == 11) begin
          repeat (half) @(posedge clk);
          #1 dev_data = 1'b1;
        end
      end
    end
  endtask

  task automatic xact(input logic [7:0] b, input bit ack, input bit inject);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(b);
    send(b);
    if (inject) begin
      fork
        device_run(11, ack);
        begin
          repeat (60) @(posedge clk);
          #1;
          i_valid = 1'b1;
          i_data  = 8'h55;
          repeat (20) @(posedge clk);
          #1 i_valid = 1'b0;
        end
      join
    end else begin
      device_run(11, ack);
    end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_pulses", done_cnt - d0, ack);
    check("err_pulses", err_cnt - e0, !ack);
    check("exp_q_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check("ready_after", o_ready, 1);
    check("clk_oe_after", o_clk_oe, 0);
    check("data_oe_after", o_data_oe, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   d0, e0, n;
    logic [7:0] b;
    bit   ack;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_data   = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_clk_oe", o_clk_oe, 0);
    check("rst_data_oe", o_data_oe, 0);
    rst = 1'b0;

    // T1: set-LEDs command
    xact(8'hED, 1'b1, 1'b0);
    check("t1_frame", cap_frame, 10'b11_1110_1101);

    // T2: parity corner bytes
    xact(8'h00, 1'b1, 1'b0);
    check("t2_frame_00", cap_frame, 10'b11_0000_0000);
    xact(8'h01, 1'b1, 1'b0);
    check("t2_frame_01", cap_frame, 10'b10_0000_0001);

    // T3: device withholds ACK
    xact(8'hF0, 1'b0, 1'b0);
    check("t3_frame", cap_frame, 10'b11_1111_0000);

    // T4: device never clocks
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5);
    n = 0;
    while (err_cnt == e0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_err", err_cnt - e0, 1);
    check("t4_done", done_cnt - d0, 0);
    check("t4_err_latency", last_err_since, INH + 1 + TMO);
    @(posedge clk); #1;
    check("t4_ready", o_ready, 1);
    check("t4_clk_oe", o_clk_oe, 0);
    check("t4_data_oe", o_data_oe, 0);

    // T5: request while busy is dropped
    xact(8'hFF, 1'b1, 1'b1);
    check("t5_frame", cap_frame, 10'b11_1111_1111);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("t5_idle_after", o_ready, 1);
    check("t5_no_extra_done", done_cnt - d0, 0);

    // T6: reset after the 4th fall, and reset during inhibit
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(8'h00);
    send(8'h00);
    device_run(4, 1'b0);
    check("t6_pre_data_oe", o_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_clk_oe", o_clk_oe, 0);
    check("t6_rst_data_oe", o_data_oe, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t6_ready", o_ready, 1);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_no_err", err_cnt - e0, 0);
    send(8'h3C);
    repeat (8) @(posedge clk);
    #1;
    check("t6_inh_clk_oe", o_clk_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_inh_rst_clk_oe", o_clk_oe, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_inh_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Randomized traffic with varying device clock rate and ACK behaviour
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom_range(0, 255));
      half = $urandom_range(8, 14);
      ack  = ($urandom_range(0, 3) != 0);
      xact(b, ack, 1'b0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
